// File: rtl/branch_pred_btb.sv
// Direct-mapped BTB with CNT_W-bit saturating counters, a table clear walker and optional gshare indexing (BPRED_GSHARE_EN).
// Lookup is combinational; updates land at the next edge. Updates arriving while clearing are dropped.
module branch_pred_btb #(
    parameter int IND_W = 8,
    parameter int CNT_W = 2,
    parameter int TAG_W = 30 - IND_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] lkp_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        clear,
    output logic        busy
`ifdef BPRED_GSHARE_EN
    ,
    output logic [IND_W-1:0] pred_ghr,
    input  logic [IND_W-1:0] upd_ghr
`endif
);

    localparam int DEPTH = 1 << IND_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [IND_W-1:0] IDX_LAST = IND_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IND_W-1:0]  clr_idx;

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [CNT_W-1:0]  cnt_mem [DEPTH];
    logic [31:0]       tgt_mem [DEPTH];

    logic [IND_W-1:0]  lkp_idx;
    logic [IND_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  lkp_tag;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_accept;
    logic              clr_we;
    logic [CNT_W-1:0]  cur_cnt;
    logic              unused_bits;

    assign lkp_tag     = lkp_pc[IND_W+2 +: TAG_W];
    assign upd_tag     = upd_pc[IND_W+2 +: TAG_W];
    assign unused_bits = ^{lkp_pc[1:0], upd_pc[1:0]};

`ifdef BPRED_GSHARE_EN
    logic [IND_W-1:0] ghr;

    assign lkp_idx  = lkp_pc[IND_W+1:2] ^ ghr;
    assign upd_idx  = upd_pc[IND_W+1:2] ^ upd_ghr;
    assign pred_ghr = ghr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ghr <= '0;
        end else if (upd_accept) begin
            ghr <= {ghr[IND_W-2:0], upd_taken};
        end
    end
`else
    assign lkp_idx = lkp_pc[IND_W+1:2];
    assign upd_idx = upd_pc[IND_W+1:2];
`endif

    // Table contents are never bypassed: lookups see the pre-edge state.
    assign pred_hit    = !busy && valid[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);
    assign pred_taken  = pred_hit && cnt_mem[lkp_idx][CNT_W-1];
    assign pred_target = pred_hit ? tgt_mem[lkp_idx] : 32'd0;

    assign upd_hit    = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign cur_cnt    = cnt_mem[upd_idx];
    assign upd_accept = !RST && (state == IDLE) && !clear && upd_valid;
    assign clr_we     = !RST && (state == CLEAR) && !clear;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
        end else if (clear) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + IND_W'(1);
            if (clr_idx == IDX_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            valid[clr_idx] <= 1'b0;
        end else if (upd_accept) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    cnt_mem[upd_idx] <= (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_W'(1);
                    tgt_mem[upd_idx] <= upd_target;
                end else begin
                    cnt_mem[upd_idx] <= (cur_cnt == '0) ? cur_cnt : cur_cnt - CNT_W'(1);
                end
            end else if (upd_taken) begin
                // Miss on a taken branch evicts whatever aliased into this slot.
                valid[upd_idx]   <= 1'b1;
                tag_mem[upd_idx] <= upd_tag;
                cnt_mem[upd_idx] <= CNT_WEAK;
                tgt_mem[upd_idx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_btb.sv
module tb_branch_pred_btb;

    logic        CLK;
    logic        RST;
    logic [31:0] lkp_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        clear;
    logic        busy;
`ifdef BPRED_GSHARE_EN
    logic [7:0]  pred_ghr;
    logic [7:0]  upd_ghr;
`endif

    int checks   = 0;
    int failures = 0;

    branch_pred_btb #(.IND_W(8), .CNT_W(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .lkp_pc      (lkp_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .clear       (clear),
        .busy        (busy)
`ifdef BPRED_GSHARE_EN
        ,
        .pred_ghr    (pred_ghr),
        .upd_ghr     (upd_ghr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] tgt);
        lkp_pc = pc;
        #1;
        check({tag, "_hit"},    32'(pred_hit),   32'(h));
        check({tag, "_taken"},  32'(pred_taken), 32'(t));
        check({tag, "_target"}, pred_target,     tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    initial begin
        int n;
        logic any_hit;

        RST = 1'b1; lkp_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; clear = 1'b0;
`ifdef BPRED_GSHARE_EN
        upd_ghr = '0;
`endif
        tick();
        RST = 1'b0;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_hit", 32'(pred_hit), 32'd0);
        check("rst_target", pred_target, 32'd0);

        n = 0;
        any_hit = 1'b0;
        while (busy === 1'b1 && n < 400) begin
            lkp_pc = n[0] ? 32'h0000_FFFC : 32'h0000_0040;
            #1;
            any_hit = any_hit | pred_hit;
            tick();
            n++;
        end
        check("rst_busy_len", 32'(n), 32'd256);
        check("rst_any_hit", 32'(any_hit), 32'd0);

`ifdef BPRED_GSHARE_EN
        check("g_ghr0", 32'(pred_ghr), 32'h00);
        upd_ghr = 8'h00;
        upd(32'h40, 1'b1, 32'h100);
        check("g_ghr1", 32'(pred_ghr), 32'h01);
        look("g_l40_miss", 32'h40, 1'b0, 1'b0, 32'h0);
        upd_ghr = 8'h01;
        upd(32'h40, 1'b1, 32'h180);
        check("g_ghr3", 32'(pred_ghr), 32'h03);
        look("g_l48_idx11", 32'h48, 1'b1, 1'b1, 32'h180);
        look("g_l4c_idx10", 32'h4C, 1'b1, 1'b1, 32'h100);
        upd_ghr = 8'h01;
        upd(32'h40, 1'b0, 32'h0);
        check("g_ghr6", 32'(pred_ghr), 32'h06);
        look("g_l5c_idx11", 32'h5C, 1'b1, 1'b0, 32'h180);
        look("g_l40_idx16", 32'h40, 1'b0, 1'b0, 32'h0);
`else
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        look("nobypass", 32'h40, 1'b0, 1'b0, 32'h0);
        tick();
        upd_valid = 1'b0;
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

        upd(32'h40, 1'b0, 32'hDEAD);
        upd(32'h40, 1'b0, 32'hDEAD);
        look("nt2", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b0, 32'hDEAD);
        upd(32'h40, 1'b1, 32'h104);
        look("sat0_then_t", 32'h40, 1'b1, 1'b0, 32'h104);
        upd(32'h40, 1'b1, 32'h104);
        upd(32'h40, 1'b1, 32'h104);
        upd(32'h40, 1'b1, 32'h104);
        look("t_sat3", 32'h40, 1'b1, 1'b1, 32'h104);
        upd(32'h40, 1'b0, 32'h0);
        look("sat3_then_nt", 32'h40, 1'b1, 1'b1, 32'h104);
        upd(32'h40, 1'b0, 32'h0);
        look("cnt1", 32'h40, 1'b1, 1'b0, 32'h104);

        look("alias_miss", 32'h440, 1'b0, 1'b0, 32'h0);
        upd(32'h440, 1'b1, 32'h200);
        look("alias_alloc", 32'h440, 1'b1, 1'b1, 32'h200);
        look("alias_evict", 32'h40, 1'b0, 1'b0, 32'h0);
        upd(32'h80, 1'b0, 32'h280);
        look("nt_noalloc", 32'h80, 1'b0, 1'b0, 32'h0);

        upd(32'h40, 1'b1, 32'h300);
        upd(32'h80, 1'b1, 32'h380);
        look("pop40", 32'h40, 1'b1, 1'b1, 32'h300);
        look("pop80", 32'h80, 1'b1, 1'b1, 32'h380);

        clear = 1'b1; upd_valid = 1'b1; upd_pc = 32'hC0; upd_taken = 1'b1; upd_target = 32'h3C0;
        tick();
        clear = 1'b0; upd_valid = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        look("clr_forced_miss", 32'h80, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i < 100; i++) tick();
        check("clr_busy99", 32'(busy), 32'd1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            if (n == 200) upd(32'h40, 1'b1, 32'h400);
            else tick();
            n++;
        end
        check("reclr_busy_len", 32'(n), 32'd256);
        look("post_clr_40", 32'h40, 1'b0, 1'b0, 32'h0);
        look("post_clr_80", 32'h80, 1'b0, 1'b0, 32'h0);
        look("post_clr_c0", 32'hC0, 1'b0, 1'b0, 32'h0);
        look("post_clr_440", 32'h440, 1'b0, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h500);
        look("post_clr_alloc", 32'h40, 1'b1, 1'b1, 32'h500);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
